// File: rtl/wb_stage_pkg.sv
// Shared MIPS definitions for the writeback stage: load-type codes, FSM states,
// link-register constants and the load alignment check.
package mips_defs;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_MEM = 2'b01,
    S_WRITE    = 2'b10,
    S_DRAIN    = 2'b11
  } wb_state_t;

  // Codes 101..111 are not named; they behave as LW.
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;

  localparam logic [4:0]  LINK_REG    = 5'd31;
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  function automatic logic load_misaligned(input logic [2:0] load_type,
                                           input logic [1:0] addr_low);
    logic is_half;
    is_half = (load_type == LT_LH) || (load_type == LT_LHU);
    if (is_half)
      return addr_low[0];
    else if (load_type[2])
      return (addr_low != 2'b00);
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data selection: picks the addressed byte or halfword from a
// little-endian word and sign- or zero-extends it according to the load type.
module load_align
  import mips_defs::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_addr_low,
  output logic [31:0] o_data
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = i_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_byte = w_lane[i_addr_low];
    w_half = i_addr_low[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_load_type)
      LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_data = {24'd0, w_byte};
      LT_LH:   o_data = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one op at a time from MEM, waits for load data when
// needed and drives the register file write port for exactly one cycle per op.
module wb_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_wreg,
  input  logic        in_regwrite,
  input  logic [31:0] in_result,
  input  logic [31:0] in_pc,
  input  logic        in_link,
  input  logic        in_is_load,
  input  logic [2:0]  in_load_type,
  input  logic [1:0]  in_addr_low,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        flush,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  output logic        RegWrite,
  output logic        busy,
  output logic        misalign_err
);

  wb_state_t   r_state;
  logic [4:0]  r_wreg;
  logic        r_regwrite;
  logic [31:0] r_result;
  logic [31:0] r_pc;
  logic        r_link;
  logic        r_is_load;
  logic [2:0]  r_load_type;
  logic [1:0]  r_addr_low;
  logic [31:0] r_load_data;
  logic [4:0]  r_wreg_out;
  logic [31:0] r_wdata_out;
  logic        r_misalign;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_we;
  logic        w_write;
  logic [4:0]  w_new_wreg;
  logic [31:0] w_new_wdata;
  logic [31:0] w_aligned;

  load_align u_align (
    .i_rdata     (dmem_rdata),
    .i_load_type (r_load_type),
    .i_addr_low  (r_addr_low),
    .o_data      (w_aligned)
  );

  assign in_ready     = (r_state == S_IDLE) || (r_state == S_WRITE);
  assign busy         = (r_state != S_IDLE);
  assign misalign_err = r_misalign;
  assign w_accept     = in_valid && in_ready && !flush;
  assign w_misaligned = load_misaligned(r_load_type, r_addr_low);

  // A link op always writes r31; otherwise r0 and misaligned loads never write.
  assign w_we = r_link ||
                (r_regwrite && (r_wreg != 5'd0) && !(r_is_load && w_misaligned));
  assign w_write     = (r_state == S_WRITE) && w_we && !flush;
  assign w_new_wreg  = r_link ? LINK_REG : r_wreg;
  assign w_new_wdata = r_link ? (r_pc + LINK_OFFSET) :
                       (r_is_load ? r_load_data : r_result);

  // The port holds the last written value whenever no write is issued.
  assign RegWrite = w_write;
  assign wreg     = w_write ? w_new_wreg  : r_wreg_out;
  assign wdata    = w_write ? w_new_wdata : r_wdata_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wreg      <= '0;
      r_regwrite  <= 1'b0;
      r_result    <= '0;
      r_pc        <= '0;
      r_link      <= 1'b0;
      r_is_load   <= 1'b0;
      r_load_type <= '0;
      r_addr_low  <= '0;
      r_load_data <= '0;
      r_wreg_out  <= '0;
      r_wdata_out <= '0;
      r_misalign  <= 1'b0;
    end else begin
      if (w_write) begin
        r_wreg_out  <= w_new_wreg;
        r_wdata_out <= w_new_wdata;
      end
      case (r_state)
        S_IDLE, S_WRITE: begin
          if (w_accept) begin
            r_wreg      <= in_wreg;
            r_regwrite  <= in_regwrite;
            r_result    <= in_result;
            r_pc        <= in_pc;
            r_link      <= in_link;
            r_is_load   <= in_is_load;
            r_load_type <= in_load_type;
            r_addr_low  <= in_addr_low;
            r_state     <= in_is_load ? S_WAIT_MEM : S_WRITE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT_MEM: begin
          if (dmem_rvalid) begin
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_load_data <= w_aligned;
              r_state     <= S_WRITE;
              if (!r_link && w_misaligned)
                r_misalign <= 1'b1;
            end
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dmem_rvalid)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst (0 = reset asserted, async assert).
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  async active-low reset.
REQ-004 in_valid  in  1  MEM stage presents an op; in_ready  out  1  stage accepts op this cycle.
REQ-005 in_wreg  in  5  destination register; in_regwrite  in  1  op writes a register.
REQ-006 in_result  in  32  ALU result; in_pc  in  32  instruction address; in_link  in  1  jal/jalr link op.
REQ-007 in_is_load  in  1  op is a load; in_load_type  in  3  load kind; in_addr_low  in  2  load byte address [1:0].
REQ-008 dmem_rvalid  in  1  load data valid; dmem_rdata  in  32  load word (little-endian).
REQ-009 flush  in  1  discard the in-flight op.
REQ-010 wreg  out  5, wdata  out  32, RegWrite  out  1  register file write port.
REQ-011 busy  out  1  state != IDLE; misalign_err  out  1  sticky misaligned-load flag.

Function
REQ-012 The FSM SHALL have four states: IDLE, WAIT_MEM, WRITE, DRAIN.
REQ-013 in_ready SHALL be 1 in IDLE and WRITE and 0 in WAIT_MEM and DRAIN.
REQ-014 On accept (in_valid & in_ready & !flush), all in_* fields SHALL be latched; non-load -> WRITE, load -> WAIT_MEM.
REQ-015 In WRITE, RegWrite SHALL be high for exactly that cycle; next state SHALL be WRITE/WAIT_MEM on a new accept, otherwise IDLE.
REQ-016 Non-load latency SHALL be 1 cycle: accept in cycle N -> RegWrite in N+1; back-to-back accepts SHALL give one write per cycle.
REQ-017 In WAIT_MEM, dmem_rvalid SHALL latch the aligned/extended data and move to WRITE (write in the cycle after rvalid).
REQ-018 dmem_rvalid in IDLE or WRITE SHALL be ignored.
REQ-019 Load types: 000 LB sign-extend byte; 001 LBU zero-extend byte; 010 LH sign-extend half; 011 LHU zero-extend half; 100 LW; 101-111 treated as LW.
REQ-020 Byte select = addr_low; half select = addr_low[1].
REQ-021 A halfword with addr_low[0]=1, or a LW with addr_low!=0, SHALL suppress RegWrite and set misalign_err.
REQ-022 in_link SHALL force wreg=31, wdata=in_pc+8 (mod 2^32) and RegWrite=1, overriding in_regwrite and in_result.
REQ-023 RegWrite SHALL be 0 whenever the latched wreg==0 or in_regwrite==0 (link excepted).
REQ-024 When RegWrite=0, wreg and wdata SHALL hold their previous values.
REQ-025 flush in WRITE SHALL suppress that cycle's write and block any accept that cycle -> IDLE.
REQ-026 flush in WAIT_MEM without rvalid -> DRAIN; with rvalid -> IDLE, data discarded.
REQ-027 DRAIN SHALL wait for dmem_rvalid, discard it, then go to IDLE; flush in IDLE/DRAIN has no effect.

Reset
REQ-028 rst=0 SHALL immediately force: state IDLE, RegWrite 0, wreg 0, wdata 0, busy 0, misalign_err 0, all latched fields 0.
REQ-029 Reset mid-WAIT_MEM SHALL abandon the load; a later dmem_rvalid is ignored (state IDLE).
REQ-030 misalign_err SHALL clear only on reset.

Structure
REQ-031 Load-type codes and FSM state encodings SHALL live in the shared mips_defs package.
REQ-032 Byte/half selection and extension SHALL be a combinational sub-module, load_align.

Verification
REQ-033 ALU op: wreg=5, result=0x1234_5678 accepted in cycle N -> RegWrite=1, wreg=5, wdata=0x12345678 in N+1 only.
REQ-034 LB with addr_low=2 and rdata=0x0080_0000, rvalid 3 cycles after accept -> wdata=0xFFFF_FF80 the cycle after rvalid; in_ready=0 while waiting.
REQ-035 LHU with addr_low=1 -> no write, misalign_err=1 and stays 1 until reset.
REQ-036 in_link with pc=0xBFC0_0010 -> wreg=31, wdata=0xBFC0_0018; in_wreg=0 with regwrite=1 -> no write.
REQ-037 flush in WAIT_MEM, rvalid 2 cycles later -> no write; in_ready=0 until DRAIN exits, then 1.
REQ-038 rst=0 asserted mid-WAIT_MEM -> outputs zeroed at once; later rvalid produces no write.
